rtc_bus_arbiter: RTL

- Shares the single RTC parallel-bus protocol engine among five requesters: init, reset, write, crono and periodic read.
- Replaces ad-hoc priority muxing of address/data at top level with a granted, transaction-locked handshake.
- Sits between the requester state machines and the RTC protocol engine.
- One bus transaction (one address byte plus one data byte, read or write) per grant.

---
 rtl/rtc_bus_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: grants the single RTC parallel-bus protocol engine to one
// of NREQ requesters (0 init, 1 reset, 2 write, 3 crono, 4 periodic read).
// Each grant covers exactly one bus transaction. The grant stays locked until
// the engine completes or the WAIT timeout expires.
//
// Optional build macro: RTC_ARB_RR_EN
//   defined   : indices 0/1 keep absolute priority, 2..NREQ-1 round-robin
//   undefined : pure fixed priority (lowest set index wins), no pointer
//
// Ports:
//   clk        in   system clock
//   Reset      in   synchronous active-high reset
//   req        in   [NREQ]     request, held until ack
//   req_rw     in   [NREQ]     1 = read, 0 = write
//   req_addr   in   [NREQ*AW]  packed addresses, requester i at [i*AW +: AW]
//   req_wdata  in   [NREQ*DW]  packed write data, same packing
//   gnt        out  [NREQ]     one-hot grant, ISSUE through WAIT
//   ack        out  [NREQ]     one-cycle completion pulse (RELEASE)
//   rdata      out  [DW]       read data, valid at ack, held to next ack
//   err        out             timeout flag, pulses with ack
//   bus_start  out             one-cycle start pulse to the engine
//   bus_rw     out             direction to the engine
//   bus_addr   out  [AW]       address to the engine
//   bus_wdata  out  [DW]       write data to the engine
//   bus_done   in              completion pulse from the engine
//   bus_rdata  in   [DW]       engine read data, valid with bus_done
module rtc_bus_arbiter #(
  parameter int unsigned NREQ    = 5,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 err,
  output logic                 bus_start,
  output logic                 bus_rw,
  output logic [AW-1:0]        bus_addr,
  output logic [DW-1:0]        bus_wdata,
  input  logic                 bus_done,
  input  logic [DW-1:0]        bus_rdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 8;
  localparam int unsigned XW = CW + 1;
  localparam logic [XW-1:0] TO_V = XW'(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]      r_state, w_state_nxt;
  logic            r_rw, w_rw_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_wdata, w_wdata_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [XW-1:0]   w_cnt_inc;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic            r_err, w_err_nxt;
  logic            r_start, w_start_nxt;
  logic [DW-1:0]   r_rdata, w_rdata_nxt;
  logic [IW-1:0]   w_pick;

`ifdef RTC_ARB_RR_EN
  logic [IW-1:0]   r_ptr, w_ptr_nxt;

  // Winner: 0 and 1 absolute; otherwise first set bit from r_ptr, wrapping in 2..NREQ-1
  always_comb begin
    int unsigned idx;
    logic        found;
    w_pick = '0;
    found  = 1'b0;
    idx    = 0;
    if (req[0]) begin
      w_pick = '0;
      found  = 1'b1;
    end else if (req[1]) begin
      w_pick = IW'(1);
      found  = 1'b1;
    end
    for (int unsigned k = 0; k < NREQ - 2; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - (NREQ - 2);
      if (!found && req[IW'(idx)]) begin
        w_pick = IW'(idx);
        found  = 1'b1;
      end
    end
  end
`else
  // Winner: lowest set index
  always_comb begin
    w_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) w_pick = IW'(i);
    end
  end
`endif

  assign w_cnt_inc = XW'(r_cnt) + XW'(1);

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = '0;
    w_ack_nxt   = '0;
    w_err_nxt   = 1'b0;
    w_start_nxt = 1'b0;
    w_rdata_nxt = r_rdata;
`ifdef RTC_ARB_RR_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_ISSUE;
          w_rw_nxt    = req_rw[w_pick];
          w_addr_nxt  = req_addr[32'(w_pick) * AW +: AW];
          w_wdata_nxt = req_wdata[32'(w_pick) * DW +: DW];
          w_gnt_nxt   = NREQ'(1) << w_pick;
          w_start_nxt = 1'b1;
`ifdef RTC_ARB_RR_EN
          if (w_pick >= IW'(2)) begin
            w_ptr_nxt = (w_pick == IW'(NREQ - 1)) ? IW'(2) : w_pick + IW'(1);
          end
`endif
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        w_gnt_nxt = r_gnt;
        w_cnt_nxt = r_cnt + CW'(1);
        // bus_done wins over a coincident timeout
        if (bus_done) begin
          w_state_nxt = S_RELEASE;
          w_gnt_nxt   = '0;
          w_ack_nxt   = r_gnt;
          if (r_rw) w_rdata_nxt = bus_rdata;
        end else if (w_cnt_inc == TO_V) begin
          w_state_nxt = S_RELEASE;
          w_gnt_nxt   = '0;
          w_ack_nxt   = r_gnt;
          w_err_nxt   = 1'b1;
          if (r_rw) w_rdata_nxt = '0;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_rdata <= '0;
`ifdef RTC_ARB_RR_EN
      r_ptr   <= IW'(2);
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rw    <= w_rw_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_start <= w_start_nxt;
      r_rdata <= w_rdata_nxt;
`ifdef RTC_ARB_RR_EN
      r_ptr   <= w_ptr_nxt;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign bus_start = r_start;
  assign bus_rw    = r_rw;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

endmodule
